// File: rtl/regfile_scoreboard.sv
// Integer register file with two combinational read ports, one write-back port,
// a per-register busy scoreboard, write-to-read bypass and a sequenced bulk clear.
module regfile_scoreboard #(
    parameter int  XLEN     = 32,
    parameter int  NREGS    = 32,
    parameter int  ZERO_REG = 1,
    parameter int  BYPASS   = 1,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_clear_req,
    output logic            o_init_busy,
    input  logic [AW-1:0]   i_rs1_addr,
    input  logic [AW-1:0]   i_rs2_addr,
    output logic [XLEN-1:0] o_rs1_data,
    output logic [XLEN-1:0] o_rs2_data,
    output logic            o_rs1_busy,
    output logic            o_rs2_busy,
    input  logic            i_issue_valid,
    input  logic [AW-1:0]   i_issue_rd,
    output logic            o_issue_ready,
    input  logic            i_wb_valid,
    input  logic [AW-1:0]   i_wb_addr,
    input  logic [XLEN-1:0] i_wb_data
);
    localparam bit            ZR   = (ZERO_REG != 0);
    localparam bit            BP   = (BYPASS != 0);
    localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

    state_t           r_state, w_state_nxt;
    logic [AW-1:0]    r_clr_cnt;
    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] r_busy, w_busy_nxt;
    logic             w_run, w_wb_en, w_fire;

    assign w_run       = (r_state == ST_RUN);
    assign o_init_busy = !w_run;
    // A clear request in RUN drops any write-back presented in the same cycle.
    assign w_wb_en     = w_run && !i_clear_req && i_wb_valid;

    // A write-back releasing the reserved register lets a new producer issue in the same cycle.
    assign o_issue_ready = w_run && !(r_busy[i_issue_rd] && !(i_wb_valid && i_wb_addr == i_issue_rd));
    assign w_fire        = i_issue_valid && o_issue_ready && !(ZR && i_issue_rd == '0);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT: if (r_clr_cnt == LAST) w_state_nxt = ST_RUN;
            ST_RUN:  if (i_clear_req)       w_state_nxt = ST_INIT;
            default: w_state_nxt = ST_INIT;
        endcase
    end

    // Set is applied after clear so a new producer supersedes the retiring one.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_run && !i_clear_req) begin
            if (i_wb_valid) w_busy_nxt[i_wb_addr]  = 1'b0;
            if (w_fire)     w_busy_nxt[i_issue_rd] = 1'b1;
        end else begin
            w_busy_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_INIT;
            r_clr_cnt <= '0;
            r_busy    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= w_busy_nxt;
            if (r_state == ST_INIT && r_clr_cnt != LAST) r_clr_cnt <= r_clr_cnt + AW'(1);
            else                                          r_clr_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (!w_run)
                r_regs[r_clr_cnt] <= '0;
            else if (w_wb_en && !(ZR && i_wb_addr == '0))
                r_regs[i_wb_addr] <= i_wb_data;
        end
    end

    logic [1:0][AW-1:0]   w_raddr;
    logic [1:0][XLEN-1:0] w_rdata;
    logic [1:0]           w_rbusy;

    assign w_raddr = {i_rs2_addr, i_rs1_addr};

    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic w_zero, w_byp;
        assign w_zero     = ZR && (w_raddr[p] == '0);
        assign w_byp      = BP && i_wb_valid && (i_wb_addr == w_raddr[p]);
        assign w_rdata[p] = (!w_run || w_zero) ? '0 : (w_byp ? i_wb_data : r_regs[w_raddr[p]]);
        assign w_rbusy[p] = w_run && !w_zero && r_busy[w_raddr[p]] && !w_byp;
    end

    assign o_rs1_data = w_rdata[0];
    assign o_rs2_data = w_rdata[1];
    assign o_rs1_busy = w_rbusy[0];
    assign o_rs2_busy = w_rbusy[1];
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench: two configurations (32x32 bypass, 16x64 no bypass) share one stimulus
// stream; an abstract model predicts every cycle's outputs and a monitor compares them.
module tb_regfile_scoreboard;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, clr = 1'b0, iv = 1'b0, wv = 1'b0;
    logic [4:0]  a1 = '0, a2 = '0, rd = '0, wa = '0;
    logic [63:0] wd = '0;

    logic        ib_a, rdy_a, b1_a, b2_a;
    logic [31:0] d1_a, d2_a;
    logic        ib_b, rdy_b, b1_b, b2_b;
    logic [63:0] d1_b, d2_b;

    regfile_scoreboard u_a (
        .clk(clk), .rst(rst), .i_clear_req(clr), .o_init_busy(ib_a),
        .i_rs1_addr(a1), .i_rs2_addr(a2), .o_rs1_data(d1_a), .o_rs2_data(d2_a),
        .o_rs1_busy(b1_a), .o_rs2_busy(b2_a),
        .i_issue_valid(iv), .i_issue_rd(rd), .o_issue_ready(rdy_a),
        .i_wb_valid(wv), .i_wb_addr(wa), .i_wb_data(wd[31:0]));

    regfile_scoreboard #(.XLEN(64), .NREGS(16), .ZERO_REG(1), .BYPASS(0)) u_b (
        .clk(clk), .rst(rst), .i_clear_req(clr), .o_init_busy(ib_b),
        .i_rs1_addr(a1[3:0]), .i_rs2_addr(a2[3:0]), .o_rs1_data(d1_b), .o_rs2_data(d2_b),
        .o_rs1_busy(b1_b), .o_rs2_busy(b2_b),
        .i_issue_valid(iv), .i_issue_rd(rd[3:0]), .o_issue_ready(rdy_b),
        .i_wb_valid(wv), .i_wb_addr(wa[3:0]), .i_wb_data(wd));

    typedef struct packed {
        logic        ib, rdy, b1, b2;
        logic [63:0] d1, d2;
    } exp_t;

    exp_t q0[$], q1[$];
    int   total = 0, bad = 0;

    // Abstract model: entering a clear wipes everything at once and simply counts down NREGS cycles.
    logic [63:0] m_reg [2][32];
    bit          m_busy[2][32];
    bit          m_run [2];
    int          m_left[2];

    function automatic int nr(input int k);            return (k == 0) ? 32 : 16; endfunction
    function automatic bit byp(input int k);           return (k == 0); endfunction
    function automatic logic [63:0] msk(input int k);  return (k == 0) ? 64'hFFFF_FFFF : '1; endfunction
    function automatic logic [4:0] am(input int k, input logic [4:0] a);
        return (k == 0) ? a : {1'b0, a[3:0]};
    endfunction

    function automatic bit hit(input int k, input logic [4:0] a);
        return wv && (am(k, wa) == am(k, a));
    endfunction

    function automatic logic [63:0] rdv(input int k, input logic [4:0] a);
        if (!m_run[k] || am(k, a) == 0) return '0;
        if (byp(k) && hit(k, a))         return wd & msk(k);
        return m_reg[k][am(k, a)];
    endfunction

    function automatic bit rbz(input int k, input logic [4:0] a);
        return m_run[k] && am(k, a) != 0 && m_busy[k][am(k, a)] && !(byp(k) && hit(k, a));
    endfunction

    function automatic exp_t expect_of(input int k);
        exp_t e;
        e.ib  = !m_run[k];
        e.rdy = m_run[k] && !(m_busy[k][am(k, rd)] && !hit(k, rd));
        e.d1  = rdv(k, a1);
        e.d2  = rdv(k, a2);
        e.b1  = rbz(k, a1);
        e.b2  = rbz(k, a2);
        return e;
    endfunction

    task automatic enter_init(input int k);
        m_run[k]  = 1'b0;
        m_left[k] = nr(k);
        for (int i = 0; i < 32; i++) begin m_reg[k][i] = '0; m_busy[k][i] = 1'b0; end
    endtask

    task automatic model_edge(input int k);
        exp_t e = expect_of(k);
        if (rst) enter_init(k);
        else if (!m_run[k]) begin
            m_left[k]--;
            if (m_left[k] == 0) m_run[k] = 1'b1;
        end else if (clr) enter_init(k);
        else begin
            if (wv) begin
                if (am(k, wa) != 0) m_reg[k][am(k, wa)] = wd & msk(k);
                m_busy[k][am(k, wa)] = 1'b0;
            end
            if (iv && e.rdy && am(k, rd) != 0) m_busy[k][am(k, rd)] = 1'b1;
        end
    endtask

    task automatic step(input bit r, input bit c, input bit v_i, input bit v_w,
                        input logic [4:0] x1, input logic [4:0] x2, input logic [4:0] xr,
                        input logic [4:0] xw, input logic [63:0] d);
        @(posedge clk); #1;
        model_edge(0);
        model_edge(1);
        rst = r; clr = c; iv = v_i; wv = v_w;
        a1 = x1; a2 = x2; rd = xr; wa = xw; wd = d;
        q0.push_back(expect_of(0));
        q1.push_back(expect_of(1));
    endtask

    function automatic logic [4:0] raddr();
        return ($urandom_range(0, 3) != 0) ? 5'($urandom_range(0, 9)) : 5'($urandom);
    endfunction

    task automatic rnd_step(input bit allow_ctl);
        bit r = allow_ctl && ($urandom_range(0, 499) == 0);
        bit c = allow_ctl && ($urandom_range(0, 149) == 0);
        step(r, c, 1'($urandom), 1'($urandom), raddr(), raddr(), raddr(), raddr(),
             {$urandom, $urandom});
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", nm, act, want, $time);
        end
    endtask

    initial begin : monitor
        exp_t ea, eb;
        forever begin
            @(negedge clk);
            if (q0.size() > 0 && q1.size() > 0) begin
                ea = q0.pop_front();
                eb = q1.pop_front();
                chk("A.init_busy", 64'(ib_a),  64'(ea.ib));
                chk("A.issue_rdy", 64'(rdy_a), 64'(ea.rdy));
                chk("A.rs1_data",  64'(d1_a),  ea.d1);
                chk("A.rs2_data",  64'(d2_a),  ea.d2);
                chk("A.rs1_busy",  64'(b1_a),  64'(ea.b1));
                chk("A.rs2_busy",  64'(b2_a),  64'(ea.b2));
                chk("B.init_busy", 64'(ib_b),  64'(eb.ib));
                chk("B.issue_rdy", 64'(rdy_b), 64'(eb.rdy));
                chk("B.rs1_data",  d1_b,       eb.d1);
                chk("B.rs2_data",  d2_b,       eb.d2);
                chk("B.rs1_busy",  64'(b1_b),  64'(eb.b1));
                chk("B.rs2_busy",  64'(b2_b),  64'(eb.b2));
            end
        end
    end

    initial begin : stim
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        // Writes and reservations presented during the clear must be ignored.
        repeat (34) rnd_step(0);
        for (int i = 0; i < 32; i++) step(0, 0, 0, 0, 5'(i), 5'(31 - i), 0, 0, 0);

        step(0, 0, 0, 1, 0, 0, 0, 5, 64'hDEAD_BEEF);
        step(0, 0, 0, 1, 5, 7, 0, 7, 64'h1234);
        step(0, 0, 0, 0, 5, 7, 0, 0, 0);

        step(0, 0, 1, 1, 0, 0, 0, 0, '1);
        step(0, 0, 1, 0, 0, 0, 0, 0, 0);

        step(0, 0, 1, 0, 9, 9, 9, 0, 0);
        step(0, 0, 1, 0, 9, 9, 9, 0, 0);
        step(0, 0, 1, 1, 9, 2, 9, 9, 64'hCAFE_F00D_0BAD_BEEF);
        step(0, 0, 0, 0, 9, 9, 9, 0, 0);
        step(0, 0, 0, 1, 9, 9, 9, 9, 64'h5);
        step(0, 0, 0, 0, 9, 9, 9, 0, 0);

        step(0, 0, 1, 1, 3, 4, 4, 3, 64'h55);
        step(0, 1, 0, 1, 3, 4, 0, 3, 64'h77);
        repeat (10) rnd_step(0);
        step(1, 0, 0, 0, 3, 4, 0, 0, 0);
        repeat (33) rnd_step(0);
        step(0, 0, 0, 0, 3, 4, 0, 0, 0);
        step(0, 0, 0, 0, 3, 4, 0, 0, 0);

        repeat (3000) rnd_step(1);

        repeat (3) @(negedge clk);
        if (q0.size() != 0 || q1.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain got=%0d want=0 pending", q0.size() + q1.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
